lsu_mem_ctrl: RTL

//  Multi-cycle load/store sequencer for the memory-access stage of the RV32I core.

---
 rtl/lsu_mem_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer for the RV32I memory stage: decodes one load/store,
// runs a req/ack data-memory access with lane alignment and timeout, and
// returns extended load data together with the register-file write enable.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TMO_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fault,
    output logic [31:0] load_data,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [1:0] F_OK     = 2'd0;
    localparam logic [1:0] F_MIS    = 2'd1;
    localparam logic [1:0] F_ILL    = 2'd2;
    localparam logic [1:0] F_TMO    = 2'd3;

    state_t             state_q, state_n;
    logic [TMO_W-1:0]   cnt_q, cnt_n;
    logic [2:0]         f3_q, f3_n;
    logic [4:0]         rd_q, rd_n;
    logic [1:0]         off_q, off_n;

    logic               busy_n, done_n, rd_we_n, mem_req_n, mem_we_n;
    logic [1:0]         fault_n;
    logic [31:0]        load_data_n, mem_addr_n, mem_wdata_n;
    logic [4:0]         rd_addr_n;
    logic [3:0]         mem_wstrb_n;

    logic               dec_load, dec_store, dec_legal, dec_mis;
    logic [2:0]         dec_f3;
    logic [3:0]         st_wstrb;
    logic [31:0]        st_wdata;
    logic               unused_ir;

    // Instruction fields beyond funct3 carry nothing for this stage.
    assign unused_ir = ^ir[31:15];

    // Decode of the incoming instruction, evaluated while IDLE.
    assign dec_f3    = ir[14:12];
    assign dec_load  = (ir[6:0] == OP_LOAD);
    assign dec_store = (ir[6:0] == OP_STORE);

    // funct3 legality and natural-alignment check for the incoming access.
    always_comb begin
        dec_legal = 1'b0;
        dec_mis   = 1'b0;
        if (dec_load) begin
            case (dec_f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_legal = 1'b1;
                default:                                dec_legal = 1'b0;
            endcase
        end else if (dec_store) begin
            dec_legal = (dec_f3 <= 3'b010);
        end
        case (dec_f3[1:0])
            2'b01:   dec_mis = addr[0];
            2'b10:   dec_mis = (addr[1:0] != 2'b00);
            default: dec_mis = 1'b0;
        endcase
    end

    // Store byte-lane strobes and lane-replicated write data.
    always_comb begin
        case (dec_f3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << addr[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    // Lane select plus sign/zero extension of a returned read word.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = rdata;
        endcase
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        f3_n        = f3_q;
        rd_n        = rd_q;
        off_n       = off_q;
        done_n      = 1'b0;
        fault_n     = F_OK;
        rd_we_n     = 1'b0;
        rd_addr_n   = rd_addr;
        load_data_n = load_data;
        mem_req_n   = 1'b0;
        mem_we_n    = 1'b0;
        mem_wstrb_n = 4'b0000;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;

        case (state_q)
            IDLE: begin
                if (start) begin
                    f3_n  = dec_f3;
                    rd_n  = ir[11:7];
                    off_n = addr[1:0];
                    if (dec_load || dec_store) begin
                        if (!dec_legal) begin
                            state_n     = FAULT;
                            done_n      = 1'b1;
                            fault_n     = F_ILL;
                            load_data_n = 32'd0;
                        end else if (dec_mis) begin
                            state_n     = FAULT;
                            done_n      = 1'b1;
                            fault_n     = F_MIS;
                            load_data_n = 32'd0;
                        end else begin
                            state_n     = REQ;
                            cnt_n       = '0;
                            mem_req_n   = 1'b1;
                            mem_we_n    = dec_store;
                            mem_addr_n  = {addr[31:2], 2'b00};
                            mem_wstrb_n = dec_store ? st_wstrb : 4'b0000;
                            mem_wdata_n = dec_store ? st_wdata : 32'd0;
                        end
                    end else begin
                        // Non-memory instruction passes straight through.
                        state_n     = RESP;
                        done_n      = 1'b1;
                        load_data_n = 32'd0;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_n = RESP;
                    done_n  = 1'b1;
                    if (mem_we) begin
                        load_data_n = 32'd0;
                    end else begin
                        load_data_n = load_extend(f3_q, off_q, mem_rdata);
                        rd_we_n     = (rd_q != 5'd0);
                        rd_addr_n   = rd_q;
                    end
                end else if (cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    state_n     = RESP;
                    done_n      = 1'b1;
                    fault_n     = F_TMO;
                    load_data_n = 32'd0;
                end else begin
                    cnt_n       = cnt_q + TMO_W'(1);
                    mem_req_n   = 1'b1;
                    mem_we_n    = mem_we;
                    mem_wstrb_n = mem_wstrb;
                end
            end
            RESP:    state_n = IDLE;
            FAULT:   state_n = IDLE;
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // State, latched operands and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            f3_q      <= 3'd0;
            rd_q      <= 5'd0;
            off_q     <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 2'd0;
            load_data <= 32'd0;
            rd_addr   <= 5'd0;
            rd_we     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            f3_q      <= f3_n;
            rd_q      <= rd_n;
            off_q     <= off_n;
            busy      <= busy_n;
            done      <= done_n;
            fault     <= fault_n;
            load_data <= load_data_n;
            rd_addr   <= rd_addr_n;
            rd_we     <= rd_we_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wstrb <= mem_wstrb_n;
            mem_wdata <= mem_wdata_n;
        end
    end

endmodule
